ed25519_frame_io: RTL and testbench
===================================

// Module: ed25519_frame_io
// PURPOSE
//  Parametrised beat<->frame adapter for the ed25519 datapath.
//  - Deserialises IN_BEATS words of DATA_W bits into one frame (M, xp, yp) and
//    presents it to the core over a valid/ready handshake.
//  - Accepts the core's OUT_BEATS-word result frame and serialises it back onto
//    the 64-bit output stream.
//  - Sits between the top-level stream ports and the point-multiplication core;
//    it is the one owner of stream beat counting.
// PARAMETERS
//  DATA_W     64   stream word width, bits
//  IN_BEATS   12   beats per input frame (768-bit frame at DATA_W=64)
//  OUT_BEATS  8    beats per result frame (512-bit frame at DATA_W=64)
//  MSB_FIRST  1    1: beat 0 fills/drains the frame MSB end; 0: beat 0 = LSB end
// PORTS
//  i_clk         in   1                    clock, all state on rising edge
//  i_rst         in   1                    reset, asynchronous, active-high
//  i_in_valid    in   1                    input beat valid
//  i_in_data     in   DATA_W               input beat
//  o_in_ready    out  1                    input beat accepted when valid&ready
//  o_frame_valid out  1                    assembled frame available to core
//  o_frame_data  out  IN_BEATS*DATA_W      assembled frame
//  i_frame_ready in   1                    core takes frame when valid&ready
//  i_res_valid   in   1                    core result frame valid
//  i_res_data    in   OUT_BEATS*DATA_W     core result frame
//  o_res_ready   out  1                    result taken when valid&ready
//  o_out_valid   out  1                    output beat valid
//  o_out_data    out  DATA_W               output beat
//  i_out_ready   in   1                    downstream accepts beat
// BEHAVIOUR
//  - All outputs are registered. While i_rst=1 every output is 0, the frame and
//    result buffers are 0, the beat counter is 0 and the state is S_COLLECT.
//    Reset asserted mid-operation aborts immediately; partial frames are dropped.
//  - o_in_ready rises on the first clock edge after reset release.
//  - FSM states:
//    S_COLLECT: o_in_ready=1. Each valid&ready writes beat k, k = counter.
//      MSB_FIRST=1 -> slice [FW-1-k*DATA_W -: DATA_W]; else [k*DATA_W +: DATA_W];
//      FW = IN_BEATS*DATA_W.
//      Exactly IN_BEATS beats are taken (counter 0..IN_BEATS-1, no extra beat).
//      On the beat where k=IN_BEATS-1: counter clears, go to S_PRESENT, and
//      o_in_ready=0 from the next cycle.
//    S_PRESENT: o_frame_valid=1, o_frame_data stable. On i_frame_ready: go to
//      S_WAIT_RES, with o_frame_valid=0 and o_res_ready=1 next cycle.
//    S_WAIT_RES: on i_res_valid&o_res_ready, latch i_res_data and go to S_EMIT.
//      o_res_ready=0, o_out_valid=1 and o_out_data=beat 0 next cycle (same slice
//      rule as input, with OUT_BEATS).
//    S_EMIT: o_out_data is held while o_out_valid&!i_out_ready. Each handshake
//      advances the counter and loads the next beat on the following cycle (no
//      bubble). After beat OUT_BEATS-1 is accepted: o_out_valid=0, back to
//      S_COLLECT, o_in_ready=1 next cycle.
//  - Input is never accepted outside S_COLLECT: i_in_valid is ignored and
//    i_in_data is not written.
//  - Frame latency: last input beat at edge N gives o_frame_valid=1 after edge N.
//  - Result latency: result accepted at edge R gives the first o_out_valid after
//    edge R.
//  - Counter width = $clog2(max(IN_BEATS,OUT_BEATS)). It wraps only via the
//    explicit clear on the last beat.
//  - i_in_valid gaps mid-frame stall collection without losing the count.
//  - o_frame_data holds its value after handoff until the next frame's first beat.
//  - Misuse: i_res_valid outside S_WAIT_RES is ignored.
// TESTING
//  - Reset then 12 beats 0x...01..0x...0C, i_frame_ready=1:
//    o_frame_data[767:704]=0x01, [63:0]=0x0C, o_frame_valid is a single-cycle
//    pulse, and o_in_ready=0 after beat 12.
//  - A 13th beat offered right after the frame: it is not accepted; the frame
//    is unchanged.
//  - Result 8 beats, i_out_ready toggling 1,0,0,1...: the beats come out in
//    order 0..7 with data stable during stalls, then o_in_ready returns to 1.
//  - MSB_FIRST=0, DATA_W=32, IN_BEATS=4: beats A,B,C,D give frame {D,C,B,A}.
//  - i_rst pulsed after beat 5 and mid-emit: all outputs are 0 immediately, and
//    the next full 12-beat frame assembles correctly.
//  - i_in_valid with gaps of 0-3 idle cycles between beats: the frame equals the
//    gapless case.

Source files
------------

// File: rtl/ed25519_frame_io_if.sv
// Handshake bundle between the stream ports, the adapter and the point-multiplication core.
// The adapter uses the slave view; the environment driving it uses the master view.
interface ed25519_frame_io_if #(
   parameter int DATA_W    = 64,
   parameter int IN_BEATS  = 12,
   parameter int OUT_BEATS = 8
);
   logic                          i_in_valid;
   logic [DATA_W-1:0]             i_in_data;
   logic                          o_in_ready;
   logic                          o_frame_valid;
   logic [IN_BEATS*DATA_W-1:0]    o_frame_data;
   logic                          i_frame_ready;
   logic                          i_res_valid;
   logic [OUT_BEATS*DATA_W-1:0]   i_res_data;
   logic                          o_res_ready;
   logic                          o_out_valid;
   logic [DATA_W-1:0]             o_out_data;
   logic                          i_out_ready;

   modport slave (
      input  i_in_valid, i_in_data, i_frame_ready, i_res_valid, i_res_data, i_out_ready,
      output o_in_ready, o_frame_valid, o_frame_data, o_res_ready, o_out_valid, o_out_data
   );

   modport master (
      output i_in_valid, i_in_data, i_frame_ready, i_res_valid, i_res_data, i_out_ready,
      input  o_in_ready, o_frame_valid, o_frame_data, o_res_ready, o_out_valid, o_out_data
   );
endinterface

// File: rtl/ed25519_frame_io.sv
// Beat<->frame adapter: collects IN_BEATS stream words into one core frame and
// drains the core's OUT_BEATS-word result frame back onto the stream.
module ed25519_frame_io #(
   parameter int DATA_W    = 64,
   parameter int IN_BEATS  = 12,
   parameter int OUT_BEATS = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   ed25519_frame_io_if.slave io
);
   localparam int FW   = IN_BEATS * DATA_W;
   localparam int OW   = OUT_BEATS * DATA_W;
   localparam int MAXB = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
   localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

   typedef enum logic [1:0] {
      S_COLLECT  = 2'd0,
      S_PRESENT  = 2'd1,
      S_WAIT_RES = 2'd2,
      S_EMIT     = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic [CW-1:0]     cnt_r;
   logic [CW-1:0]     cnt_nx_s;
   logic              in_ready_r;
   logic              in_ready_nx_s;
   logic              frame_valid_r;
   logic              frame_valid_nx_s;
   logic [FW-1:0]     frame_data_r;
   logic              res_ready_r;
   logic              res_ready_nx_s;
   logic [OW-1:0]     res_buf_r;
   logic              out_valid_r;
   logic              out_valid_nx_s;
   logic [DATA_W-1:0] out_data_r;
   logic [DATA_W-1:0] out_data_nx_s;
   logic              in_take_s;
   logic              res_take_s;

   // Beat k lands in the slot counted from the MSB end or the LSB end of the frame.
   function automatic logic [FW-1:0] frame_put(input logic [FW-1:0]     frame,
                                               input logic [CW-1:0]     k,
                                               input logic [DATA_W-1:0] beat);
      logic [FW-1:0] f;
      f = frame;
      for (int b = 0; b < IN_BEATS; b++) begin
         if (int'(k) == b) begin
            if (MSB_FIRST != 0) begin
               f[(IN_BEATS-1-b)*DATA_W +: DATA_W] = beat;
            end else begin
               f[b*DATA_W +: DATA_W] = beat;
            end
         end
      end
      return f;
   endfunction

   function automatic logic [DATA_W-1:0] out_beat(input logic [OW-1:0] res,
                                                  input int            k);
      logic [DATA_W-1:0] r;
      r = {DATA_W{1'b0}};
      for (int b = 0; b < OUT_BEATS; b++) begin
         if (k == b) begin
            if (MSB_FIRST != 0) begin
               r = res[(OUT_BEATS-1-b)*DATA_W +: DATA_W];
            end else begin
               r = res[b*DATA_W +: DATA_W];
            end
         end
      end
      return r;
   endfunction

   // Next-state, counter and next registered-output values.
   always_comb begin
      state_nx_s    = state_r;
      cnt_nx_s      = cnt_r;
      out_data_nx_s = out_data_r;
      in_take_s     = 1'b0;
      res_take_s    = 1'b0;
      case (state_r)
         S_COLLECT: begin
            in_take_s = io.i_in_valid & in_ready_r;
            if (in_take_s) begin
               if (cnt_r == CW'(IN_BEATS-1)) begin
                  cnt_nx_s   = {CW{1'b0}};
                  state_nx_s = S_PRESENT;
               end else begin
                  cnt_nx_s   = cnt_r + CW'(1);
               end
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         S_PRESENT: begin
            if (io.i_frame_ready & frame_valid_r) begin
               state_nx_s = S_WAIT_RES;
            end else begin
               state_nx_s = S_PRESENT;
            end
         end
         S_WAIT_RES: begin
            res_take_s = io.i_res_valid & res_ready_r;
            if (res_take_s) begin
               state_nx_s    = S_EMIT;
               cnt_nx_s      = {CW{1'b0}};
               out_data_nx_s = out_beat(io.i_res_data, 0);
            end else begin
               state_nx_s = S_WAIT_RES;
            end
         end
         S_EMIT: begin
            // Stall holds the current beat; a handshake loads the next one with no bubble.
            if (out_valid_r & io.i_out_ready) begin
               if (cnt_r == CW'(OUT_BEATS-1)) begin
                  cnt_nx_s   = {CW{1'b0}};
                  state_nx_s = S_COLLECT;
               end else begin
                  cnt_nx_s      = cnt_r + CW'(1);
                  out_data_nx_s = out_beat(res_buf_r, int'(cnt_r) + 1);
               end
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         default: begin
            state_nx_s = S_COLLECT;
            cnt_nx_s   = {CW{1'b0}};
         end
      endcase
      in_ready_nx_s    = (state_nx_s == S_COLLECT);
      frame_valid_nx_s = (state_nx_s == S_PRESENT);
      res_ready_nx_s   = (state_nx_s == S_WAIT_RES);
      out_valid_nx_s   = (state_nx_s == S_EMIT);
   end

   // State, counter, buffers and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r       <= S_COLLECT;
         cnt_r         <= {CW{1'b0}};
         in_ready_r    <= 1'b0;
         frame_valid_r <= 1'b0;
         frame_data_r  <= {FW{1'b0}};
         res_ready_r   <= 1'b0;
         res_buf_r     <= {OW{1'b0}};
         out_valid_r   <= 1'b0;
         out_data_r    <= {DATA_W{1'b0}};
      end else begin
         state_r       <= state_nx_s;
         cnt_r         <= cnt_nx_s;
         in_ready_r    <= in_ready_nx_s;
         frame_valid_r <= frame_valid_nx_s;
         res_ready_r   <= res_ready_nx_s;
         out_valid_r   <= out_valid_nx_s;
         out_data_r    <= out_data_nx_s;
         if (in_take_s) begin
            frame_data_r <= frame_put(frame_data_r, cnt_r, io.i_in_data);
         end
         if (res_take_s) begin
            res_buf_r <= io.i_res_data;
         end
      end
   end

   assign io.o_in_ready    = in_ready_r;
   assign io.o_frame_valid = frame_valid_r;
   assign io.o_frame_data  = frame_data_r;
   assign io.o_res_ready   = res_ready_r;
   assign io.o_out_valid   = out_valid_r;
   assign io.o_out_data    = out_data_r;
endmodule

// File: tb/tb_ed25519_frame_io.sv
// Directed + randomized bench for ed25519_frame_io: a 64-bit MSB-first instance and a
// 32-bit LSB-first instance, checked against a shift/or frame model.
`timescale 1ns/1ps
module tb_ed25519_frame_io;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ed25519_frame_io_if #(.DATA_W(64), .IN_BEATS(12), .OUT_BEATS(8)) io0 ();
   ed25519_frame_io_if #(.DATA_W(32), .IN_BEATS(4),  .OUT_BEATS(2)) io1 ();

   ed25519_frame_io #(.DATA_W(64), .IN_BEATS(12), .OUT_BEATS(8), .MSB_FIRST(1)) u0 (
      .i_clk(clk), .i_rst(rst), .io(io0));
   ed25519_frame_io #(.DATA_W(32), .IN_BEATS(4), .OUT_BEATS(2), .MSB_FIRST(0)) u1 (
      .i_clk(clk), .i_rst(rst), .io(io1));

   logic [63:0]  beats0 [12];
   logic [767:0] exp_frame0;

   task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Beat 0 ends up in the top word: shift the running frame up and or in each beat.
   function automatic logic [767:0] model_frame0();
      logic [767:0] f;
      f = 768'd0;
      for (int i = 0; i < 12; i++) f = (f << 64) | 768'(beats0[i]);
      return f;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      r = 512'd0;
      for (int j = 0; j < 16; j++) r = {r[479:0], 32'($urandom)};
      return r;
   endfunction

   task automatic rst_chk(input string tag);
      chk({tag, "_in_ready0"},    768'(io0.o_in_ready),    768'd0);
      chk({tag, "_frame_valid0"}, 768'(io0.o_frame_valid), 768'd0);
      chk({tag, "_frame_data0"},  io0.o_frame_data,        768'd0);
      chk({tag, "_res_ready0"},   768'(io0.o_res_ready),   768'd0);
      chk({tag, "_out_valid0"},   768'(io0.o_out_valid),   768'd0);
      chk({tag, "_out_data0"},    768'(io0.o_out_data),    768'd0);
      chk({tag, "_in_ready1"},    768'(io1.o_in_ready),    768'd0);
      chk({tag, "_out_valid1"},   768'(io1.o_out_valid),   768'd0);
   endtask

   task automatic push0(input logic [63:0] d);
      int   t;
      logic ok;
      io0.i_in_valid = 1'b1;
      io0.i_in_data  = d;
      t = 0;
      do begin
         ok = io0.o_in_ready;
         cyc();
         t++;
      end while (!ok && t < 40);
      io0.i_in_valid = 1'b0;
      chk("push_accept", 768'(ok), 768'd1);
   endtask

   task automatic send_frame0(input int maxgap);
      int g;
      exp_frame0 = model_frame0();
      for (int i = 0; i < 12; i++) begin
         push0(beats0[i]);
         if (i < 11 && maxgap > 0) begin
            g = $urandom_range(maxgap, 0);
            repeat (g) cyc();
         end
      end
      chk("frame_valid", 768'(io0.o_frame_valid), 768'd1);
      chk("in_ready_low", 768'(io0.o_in_ready), 768'd0);
      chk("frame_data", io0.o_frame_data, exp_frame0);
   endtask

   // mode 0: out_ready pattern 1,0,0,1,0,0...; mode 1: random out_ready.
   task automatic emit0(input logic [511:0] res, input int mode, input int stop);
      int          t, k, c;
      logic        ok;
      logic [63:0] e;
      io0.i_res_valid = 1'b1;
      io0.i_res_data  = res;
      t = 0;
      do begin
         ok = io0.o_res_ready;
         cyc();
         t++;
      end while (!ok && t < 40);
      io0.i_res_valid = 1'b0;
      chk("res_accept", 768'(ok), 768'd1);
      chk("res_ready_drop", 768'(io0.o_res_ready), 768'd0);
      k = 0;
      c = 0;
      while (k < stop && c < 200) begin
         e = 64'(res >> (64 * (7 - k)));
         chk("out_valid", 768'(io0.o_out_valid), 768'd1);
         chk("out_beat", 768'(io0.o_out_data), 768'(e));
         io0.i_out_ready = (mode == 0) ? (c % 3 == 0) : 1'($urandom_range(1, 0));
         cyc();
         if (io0.i_out_ready) k++;
         c++;
      end
      io0.i_out_ready = 1'b0;
      chk("emit_count", 768'(k), 768'(stop));
   endtask

   task automatic push1(input logic [31:0] d);
      int   t;
      logic ok;
      io1.i_in_valid = 1'b1;
      io1.i_in_data  = d;
      t = 0;
      do begin
         ok = io1.o_in_ready;
         cyc();
         t++;
      end while (!ok && t < 40);
      io1.i_in_valid = 1'b0;
      chk("push1_accept", 768'(ok), 768'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [511:0] res;
      logic [31:0]  b1 [4];
      logic [127:0] exp1;
      logic [63:0]  res1;

      rst = 1'b1;
      io0.i_in_valid = 1'b0; io0.i_in_data = 64'd0; io0.i_frame_ready = 1'b0;
      io0.i_res_valid = 1'b0; io0.i_res_data = 512'd0; io0.i_out_ready = 1'b0;
      io1.i_in_valid = 1'b0; io1.i_in_data = 32'd0; io1.i_frame_ready = 1'b0;
      io1.i_res_valid = 1'b0; io1.i_res_data = 64'd0; io1.i_out_ready = 1'b0;
      repeat (2) cyc();
      rst_chk("reset");
      rst = 1'b0;
      #1;
      chk("ready_before_edge", 768'(io0.o_in_ready), 768'd0);
      cyc();
      chk("ready_after_release0", 768'(io0.o_in_ready), 768'd1);
      chk("ready_after_release1", 768'(io1.o_in_ready), 768'd1);

      // Counting beats 1..12 with the core always ready.
      for (int i = 0; i < 12; i++) beats0[i] = 64'(i + 1);
      io0.i_frame_ready = 1'b1;
      send_frame0(0);
      chk("frame_top_word", 768'(io0.o_frame_data[767:704]), 768'h1);
      chk("frame_low_word", 768'(io0.o_frame_data[63:0]), 768'hC);
      cyc();
      chk("frame_pulse", 768'(io0.o_frame_valid), 768'd0);
      chk("res_ready_up", 768'(io0.o_res_ready), 768'd1);
      chk("in_ready_still_low", 768'(io0.o_in_ready), 768'd0);

      // A 13th beat is refused and must not touch the frame.
      io0.i_in_valid = 1'b1;
      io0.i_in_data  = 64'hDEAD_BEEF_CAFE_F00D;
      repeat (3) cyc();
      chk("extra_beat_ready", 768'(io0.o_in_ready), 768'd0);
      chk("extra_beat_frame", io0.o_frame_data, exp_frame0);
      io0.i_in_valid = 1'b0;

      res = rand512();
      emit0(res, 0, 8);
      chk("emit_done_valid", 768'(io0.o_out_valid), 768'd0);
      chk("emit_done_ready", 768'(io0.o_in_ready), 768'd1);

      // Result offered while collecting is ignored.
      io0.i_res_valid = 1'b1;
      io0.i_res_data  = rand512();
      repeat (2) cyc();
      chk("misuse_res_ready", 768'(io0.o_res_ready), 768'd0);
      chk("misuse_out_valid", 768'(io0.o_out_valid), 768'd0);
      io0.i_res_valid = 1'b0;

      // Random beats with idle gaps, core holding off for a few cycles.
      io0.i_frame_ready = 1'b0;
      for (int i = 0; i < 12; i++) beats0[i] = {32'($urandom), 32'($urandom)};
      send_frame0(3);
      repeat (3) begin
         cyc();
         chk("hold_valid", 768'(io0.o_frame_valid), 768'd1);
         chk("hold_data", io0.o_frame_data, exp_frame0);
      end
      io0.i_frame_ready = 1'b1;
      cyc();
      io0.i_frame_ready = 1'b0;
      chk("handoff_valid", 768'(io0.o_frame_valid), 768'd0);
      emit0(rand512(), 1, 8);
      chk("gap_emit_ready", 768'(io0.o_in_ready), 768'd1);

      // Same beats gapless must give the same frame.
      send_frame0(0);
      io0.i_frame_ready = 1'b1;
      cyc();
      emit0(rand512(), 1, 8);

      // Reset after beat 5 drops the partial frame.
      for (int i = 0; i < 5; i++) push0(64'($urandom));
      rst = 1'b1;
      #1;
      rst_chk("rst_mid_frame");
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) beats0[i] = {32'($urandom), 32'($urandom)};
      send_frame0(1);
      cyc();
      emit0(rand512(), 0, 3);

      // Reset in the middle of emission.
      rst = 1'b1;
      #1;
      rst_chk("rst_mid_emit");
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) beats0[i] = {32'($urandom), 32'($urandom)};
      send_frame0(0);
      cyc();
      emit0(rand512(), 1, 8);
      chk("after_rst_ready", 768'(io0.o_in_ready), 768'd1);

      // LSB-first 32-bit instance: beats A,B,C,D give {D,C,B,A}.
      exp1 = 128'd0;
      for (int i = 0; i < 4; i++) begin
         b1[i] = $urandom;
         exp1  = exp1 | (128'(b1[i]) << (32 * i));
      end
      io1.i_frame_ready = 1'b1;
      for (int i = 0; i < 4; i++) push1(b1[i]);
      chk("lsb_frame_valid", 768'(io1.o_frame_valid), 768'd1);
      chk("lsb_frame_data", 768'(io1.o_frame_data), 768'(exp1));
      cyc();
      chk("lsb_res_ready", 768'(io1.o_res_ready), 768'd1);
      res1 = {32'($urandom), 32'($urandom)};
      io1.i_res_valid = 1'b1;
      io1.i_res_data  = res1;
      cyc();
      io1.i_res_valid = 1'b0;
      chk("lsb_out_valid0", 768'(io1.o_out_valid), 768'd1);
      chk("lsb_out_beat0", 768'(io1.o_out_data), 768'(res1[31:0]));
      io1.i_out_ready = 1'b1;
      cyc();
      chk("lsb_out_valid1", 768'(io1.o_out_valid), 768'd1);
      chk("lsb_out_beat1", 768'(io1.o_out_data), 768'(res1[63:32]));
      cyc();
      io1.i_out_ready = 1'b0;
      chk("lsb_out_done", 768'(io1.o_out_valid), 768'd0);
      chk("lsb_in_ready", 768'(io1.o_in_ready), 768'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
